pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Power-up and lock-supervision sequencer for the three-output system PLL (100 MHz SDRAM/core, 50 MHz).
//  Runs on the free-running 50 MHz board reference clock. Drives the PLL reset, synchronises the PLL's
//  asynchronous locked flag and requires lock to be stable before releasing resets in order:
//  SDRAM controller reset first, then core reset. Re-issues the PLL reset on lock timeout or lock loss.
// PARAMETERS
//  PLL_RST_CYCLES      16     clk cycles pll_rst is held high per attempt (>=1)
//  LOCK_STABLE_CYCLES  1024   consecutive synced-lock cycles required before releasing sdram_rst (>=1)
//  LOCK_TIMEOUT_CYCLES 65536  cycles allowed in WAITLOCK before retrying the PLL reset (>=2)
//  SDRAM_INIT_CYCLES   5000   cycles between sdram_rst and sys_rst release (100 us @ 50 MHz) (>=1)
//  SYNC_STAGES         2      flops in the pll_locked synchroniser (>=2)
// PORTS
//  clk          in   1  50 MHz reference clock, also feeds the PLL refclk
//  rst          in   1  synchronous, active-high reset
//  pll_locked   in   1  PLL locked flag, asynchronous to clk
//  pll_rst      out  1  reset to the PLL, active-high
//  sdram_rst    out  1  reset to the SDRAM controller domain, active-high
//  sys_rst      out  1  reset to the core logic, active-high
//  ready        out  1  high only in RUN
//  lock_lost    out  1  one-cycle pulse when lock is lost in SDRAM_WAIT or RUN
//  retry_count  out  4  PLL reset retries since rst, saturates at 15
//  state        out  3  current state encoding (debug)
// BEHAVIOUR
//  - All outputs registered. On rst: state=PLLRST (0), counter=0, pll_rst=1, sdram_rst=1,
//    sys_rst=1, ready=0, lock_lost=0, retry_count=0, synchroniser flops cleared to 0.
//  - lk = output of the SYNC_STAGES-flop chain on pll_locked; all decisions use lk only.
//  - Single down/up counter, width = clog2 of the largest cycle parameter; cleared on every state change.
//  - States / encoding: PLLRST=0, WAITLOCK=1, STABLE=2, SDRAM_WAIT=3, RUN=4.
//  - PLLRST: pll_rst=1, sdram_rst=1, sys_rst=1. After PLL_RST_CYCLES cycles in state -> WAITLOCK.
//  - WAITLOCK: pll_rst=0. lk=1 -> STABLE. Else counter++; when counter reaches
//    LOCK_TIMEOUT_CYCLES-1 with lk=0 -> PLLRST, retry_count++ (saturating).
//  - STABLE: lk=0 -> WAITLOCK (counter restarts, no retry increment). LOCK_STABLE_CYCLES
//    consecutive cycles with lk=1 -> SDRAM_WAIT; sdram_rst goes 0 on the entry edge.
//  - SDRAM_WAIT: sys_rst stays 1. After SDRAM_INIT_CYCLES cycles -> RUN; sys_rst=0, ready=1 on entry edge.
//  - RUN: holds indefinitely while lk=1.
//  - Lock loss (lk=0 in SDRAM_WAIT or RUN): next edge -> PLLRST with pll_rst=1, sdram_rst=1,
//    sys_rst=1, ready=0, lock_lost=1 for exactly that one cycle, retry_count++ (saturating).
//    Lock loss has priority over a same-cycle counter expiry.
//  - Latency pll_locked fall -> resets asserted: SYNC_STAGES+1 clk edges.
//  - Invariant: sys_rst=0 implies sdram_rst=0 implies pll_rst=0; ready == (state==RUN).
//  - rst asserted in any state restores reset values on the next edge; retry_count cleared.
//  - Glitches on pll_locked shorter than one clk never produce an X; stable window restarts on any lk=0.
// TESTING (bench params: PLL_RST=4, LOCK_STABLE=8, TIMEOUT=32, SDRAM_INIT=16, SYNC=2)
//  1 Reset then pll_locked=1 from cycle 6 -> pll_rst low after 4 cycles; sdram_rst falls 8 cycles after
//    lk rises; sys_rst falls and ready rises 16 cycles later; retry_count=0.
//  2 pll_locked held 0 -> pll_rst re-pulses every 4+32 cycles; retry_count 1,2,...,15 and stays 15.
//  3 In STABLE, drop pll_locked for 1 cycle at stable count 5 -> returns to WAITLOCK, full 8-cycle
//    window required again, retry_count unchanged, sdram_rst stays 1.
//  4 In RUN, drop pll_locked -> 3 edges later all resets=1, ready=0, single lock_lost pulse,
//    retry_count+1, full sequence repeats when lock returns.
//  5 Lock drop on the same cycle SDRAM_WAIT counter expires -> goes to PLLRST, never enters RUN.
//  6 Assert rst mid-SDRAM_WAIT -> next edge all outputs at reset values, state=0, retry_count=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-supervision sequencer: drives the PLL reset, synchronises pll_locked and
// releases the SDRAM and core resets in order once lock has been stable long enough.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned SDRAM_INIT_CYCLES   = 5000,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > SDRAM_INIT_CYCLES) ?
                                    LOCK_TIMEOUT_CYCLES : SDRAM_INIT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SDRAM_LAST   = CNT_W'(SDRAM_INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PLLRST     = 3'd0,
    ST_WAITLOCK   = 3'd1,
    ST_STABLE     = 3'd2,
    ST_SDRAM_WAIT = 3'd3,
    ST_RUN        = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             retry_q, retry_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sdram_rst_q, sdram_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lk;
  logic [3:0]             retry_inc;

  assign lk        = sync_q[SYNC_STAGES-1];
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == PLL_RST_LAST) state_d = ST_WAITLOCK;
      end
      ST_WAITLOCK: begin
        if (lk) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLLRST;
          retry_d = retry_inc;
        end
      end
      ST_STABLE: begin
        if (!lk) begin
          state_d = ST_WAITLOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_SDRAM_WAIT;
        end
      end
      ST_SDRAM_WAIT: begin
        // Lock loss is tested first so it wins over a same-cycle init expiry.
        if (!lk) begin
          state_d     = ST_PLLRST;
          retry_d     = retry_inc;
          lock_lost_d = 1'b1;
        end else if (cnt_q == SDRAM_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lk) begin
          state_d     = ST_PLLRST;
          retry_d     = retry_inc;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_PLLRST;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs decode the next state so they change on the same edge as the state itself.
    pll_rst_d   = (state_d == ST_PLLRST);
    sdram_rst_d = (state_d == ST_PLLRST) || (state_d == ST_WAITLOCK) || (state_d == ST_STABLE);
    sys_rst_d   = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= '0;
      sync_q      <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sdram_rst_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sdram_rst_q <= sdram_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sdram_rst   = sdram_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed lock scenarios plus random lock/glitch traffic,
// checked every cycle against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

  localparam int P_RST  = 4;
  localparam int P_STB  = 8;
  localparam int P_TO   = 32;
  localparam int P_SDR  = 16;
  localparam int P_SYNC = 2;

  localparam int PH_PLLRST   = 0;
  localparam int PH_WAITLOCK = 1;
  localparam int PH_STABLE   = 2;
  localparam int PH_SDRAM    = 3;
  localparam int PH_RUN      = 4;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sdram_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  bit mon_run  = 0;
  bit saw_run  = 0;

  // Reference model: phase, cycles elapsed in phase, lock delay line.
  int   m_ph    = PH_PLLRST;
  int   m_t     = 0;
  int   m_retry = 0;
  bit   m_lost  = 0;
  logic m_hist [P_SYNC];

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_STABLE_CYCLES  (P_STB),
    .LOCK_TIMEOUT_CYCLES (P_TO),
    .SDRAM_INIT_CYCLES   (P_SDR),
    .SYNC_STAGES         (P_SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sdram_rst   (sdram_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .state       (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic pl);
    logic lk;
    if (r) begin
      m_ph = PH_PLLRST; m_t = 0; m_retry = 0; m_lost = 0;
      for (int i = 0; i < P_SYNC; i++) m_hist[i] = 1'b0;
    end else begin
      lk = m_hist[P_SYNC-1];
      for (int i = P_SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pl;
      m_lost = 0;
      m_t++;
      case (m_ph)
        PH_PLLRST:   if (m_t == P_RST) begin m_ph = PH_WAITLOCK; m_t = 0; end
        PH_WAITLOCK: begin
          if (lk) begin m_ph = PH_STABLE; m_t = 0; end
          else if (m_t == P_TO) begin
            m_ph = PH_PLLRST; m_t = 0;
            if (m_retry < 15) m_retry++;
          end
        end
        PH_STABLE: begin
          if (!lk) begin m_ph = PH_WAITLOCK; m_t = 0; end
          else if (m_t == P_STB) begin m_ph = PH_SDRAM; m_t = 0; end
        end
        PH_SDRAM, PH_RUN: begin
          if (!lk) begin
            m_ph = PH_PLLRST; m_t = 0; m_lost = 1;
            if (m_retry < 15) m_retry++;
          end else if (m_ph == PH_SDRAM && m_t == P_SDR) begin
            m_ph = PH_RUN; m_t = 0;
          end
        end
        default: m_ph = PH_PLLRST;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(rst, pll_locked);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("state",     32'(state),       32'(m_ph));
      check_eq("pll_rst",   32'(pll_rst),     32'(m_ph == PH_PLLRST));
      check_eq("sdram_rst", 32'(sdram_rst),   32'(m_ph <= PH_STABLE));
      check_eq("sys_rst",   32'(sys_rst),     32'(m_ph != PH_RUN));
      check_eq("ready",     32'(ready),       32'(m_ph == PH_RUN));
      check_eq("lock_lost", 32'(lock_lost),   32'(m_lost));
      check_eq("retry",     32'(retry_count), 32'(m_retry));
    end
    if (mon_run && ready === 1'b1) saw_run = 1;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int unsigned budget);
    int unsigned n = 0;
    while (state !== s && n < budget) begin
      tick(1);
      n++;
    end
    check_eq("reach_state", 32'(state), 32'(s));
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    tick(3);
    rst = 1'b0;
    chk_en = 1;

    // Lock arrives a few cycles after reset and the full release sequence runs.
    tick(5);
    pll_locked = 1'b1;
    wait_state(3'd4, 100);
    @(negedge clk);
    check_eq("s1_ready", 32'(ready), 32'd1);
    check_eq("s1_retry", 32'(retry_count), 32'd0);

    // Lock loss in RUN: resets come back three edges later with a single pulse.
    tick(1);
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("s4_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("s4_sys_rst", 32'(sys_rst), 32'd1);
    check_eq("s4_lost",    32'(lock_lost), 32'd1);
    check_eq("s4_retry",   32'(retry_count), 32'd1);
    @(negedge clk);
    check_eq("s4_lost_end", 32'(lock_lost), 32'd0);
    tick(1);
    pll_locked = 1'b1;

    // One-cycle lk dip at stable count 5 restarts the window from WAITLOCK.
    wait_state(3'd2, 100);
    tick(3);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("s3_state", 32'(state), 32'd1);
    check_eq("s3_sdram", 32'(sdram_rst), 32'd1);
    check_eq("s3_retry", 32'(retry_count), 32'd1);
    tick(1);

    // lk dip lands exactly on the SDRAM_WAIT expiry edge: must not enter RUN.
    wait_state(3'd3, 100);
    saw_run = 0;
    mon_run = 1;
    tick(13);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("s5_state", 32'(state), 32'd0);
    check_eq("s5_lost",  32'(lock_lost), 32'd1);
    tick(10);
    mon_run = 0;
    check_eq("s5_no_run", 32'(saw_run), 32'd0);

    // Reset mid SDRAM_WAIT.
    wait_state(3'd3, 200);
    tick(5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("s6_state",     32'(state), 32'd0);
    check_eq("s6_retry",     32'(retry_count), 32'd0);
    check_eq("s6_sdram_rst", 32'(sdram_rst), 32'd1);
    check_eq("s6_ready",     32'(ready), 32'd0);
    tick(1);
    rst = 1'b0;

    // No lock at all: retries every PLL_RST + TIMEOUT cycles, saturating at 15.
    pll_locked = 1'b0;
    tick(620);
    @(negedge clk);
    check_eq("s2_retry_sat", 32'(retry_count), 32'd15);
    tick(1);

    // Random lock levels with sub-cycle glitches and occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      int unsigned len;
      logic        lvl;
      len = $urandom_range(1, 80);
      lvl = ($urandom_range(0, 3) != 0);
      pll_locked = lvl;
      for (int k = 0; k < int'(len); k++) begin
        tick(1);
        if ($urandom_range(0, 15) == 0) begin
          pll_locked = ~lvl;
          #1;
          pll_locked = lvl;
        end
      end
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end

    tick(2);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
